// File: rtl/mesi_isc_broad_sched.sv
// Broadcast scheduler: pops one broadcast FIFO entry at a time, snoops every CPU except
// the originator, then grants the originator its enable command before popping the entry.
module mesi_isc_broad_sched #(
   parameter int unsigned CBUS_CMD_WIDTH   = 3,
   parameter int unsigned ADDR_WIDTH       = 32,
   parameter int unsigned BROAD_TYPE_WIDTH = 2,
   parameter int unsigned BROAD_ID_WIDTH   = 7
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          broad_fifo_status_empty_i,
   input  logic [ADDR_WIDTH-1:0]         broad_addr_i,
   input  logic [BROAD_TYPE_WIDTH-1:0]   broad_type_i,
   input  logic [1:0]                    broad_cpu_id_i,
   input  logic [BROAD_ID_WIDTH-1:0]     broad_id_i,
   input  logic [3:0]                    cbus_ack_array_i,
   output logic                          broad_fifo_rd_o,
   output logic [4*CBUS_CMD_WIDTH-1:0]   cbus_cmd_array_o,
   output logic [ADDR_WIDTH-1:0]         cbus_addr_o,
   output logic [BROAD_ID_WIDTH-1:0]     active_id_o,
   output logic                          busy_o,
   output logic [15:0]                   done_cnt_o
);

   localparam logic [BROAD_TYPE_WIDTH-1:0] TypeWr = BROAD_TYPE_WIDTH'(1);
   localparam logic [BROAD_TYPE_WIDTH-1:0] TypeRd = BROAD_TYPE_WIDTH'(2);

   localparam logic [CBUS_CMD_WIDTH-1:0] CmdNop     = CBUS_CMD_WIDTH'(0);
   localparam logic [CBUS_CMD_WIDTH-1:0] CmdWrSnoop = CBUS_CMD_WIDTH'(1);
   localparam logic [CBUS_CMD_WIDTH-1:0] CmdRdSnoop = CBUS_CMD_WIDTH'(2);
   localparam logic [CBUS_CMD_WIDTH-1:0] CmdEnWr    = CBUS_CMD_WIDTH'(3);
   localparam logic [CBUS_CMD_WIDTH-1:0] CmdEnRd    = CBUS_CMD_WIDTH'(4);

   typedef enum logic [1:0] {StIdle, StSnoop, StEnable, StDone} state_t;

   state_t                        r_state, w_state_d;
   logic [3:0]                    r_pending, w_pending_d;
   logic [ADDR_WIDTH-1:0]         r_addr, w_addr_d;
   logic [BROAD_TYPE_WIDTH-1:0]   r_type, w_type_d;
   logic [1:0]                    r_cpu, w_cpu_d;
   logic [BROAD_ID_WIDTH-1:0]     r_id, w_id_d;
   logic [15:0]                   r_done_cnt, w_done_cnt_d;

   logic                          w_type_valid;
   logic [3:0]                    w_cpu_onehot;
   logic [3:0][CBUS_CMD_WIDTH-1:0] w_cmd;

   assign w_type_valid = (broad_type_i == TypeWr) || (broad_type_i == TypeRd);
   assign w_cpu_onehot = 4'b0001 << broad_cpu_id_i;

   always_comb begin
      w_state_d    = r_state;
      w_pending_d  = r_pending;
      w_addr_d     = r_addr;
      w_type_d     = r_type;
      w_cpu_d      = r_cpu;
      w_id_d       = r_id;
      w_done_cnt_d = r_done_cnt;
      case (r_state)
         StIdle: begin
            if (!broad_fifo_status_empty_i) begin
               w_addr_d = broad_addr_i;
               w_type_d = broad_type_i;
               w_cpu_d  = broad_cpu_id_i;
               w_id_d   = broad_id_i;
               // Invalid types are dropped: popped without touching the bus.
               if (w_type_valid) begin
                  w_pending_d = 4'hF & ~w_cpu_onehot;
                  w_state_d   = StSnoop;
               end else begin
                  w_state_d = StDone;
               end
            end
         end
         StSnoop: begin
            w_pending_d = r_pending & ~cbus_ack_array_i;
            if (w_pending_d == 4'h0) begin
               w_state_d = StEnable;
            end
         end
         StEnable: begin
            if (cbus_ack_array_i[r_cpu]) begin
               w_state_d    = StDone;
               w_done_cnt_d = r_done_cnt + 16'd1;
            end
         end
         StDone: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_pending  <= '0;
         r_addr     <= '0;
         r_type     <= '0;
         r_cpu      <= '0;
         r_id       <= '0;
         r_done_cnt <= '0;
      end else begin
         r_state    <= w_state_d;
         r_pending  <= w_pending_d;
         r_addr     <= w_addr_d;
         r_type     <= w_type_d;
         r_cpu      <= w_cpu_d;
         r_id       <= w_id_d;
         r_done_cnt <= w_done_cnt_d;
      end
   end

   // Commands decode from registered state only, so they stay stable until acked.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_cmd[i] = CmdNop;
      end
      case (r_state)
         StSnoop: begin
            for (int i = 0; i < 4; i++) begin
               if (r_pending[i]) begin
                  w_cmd[i] = (r_type == TypeWr) ? CmdWrSnoop : CmdRdSnoop;
               end
            end
         end
         StEnable: begin
            w_cmd[r_cpu] = (r_type == TypeWr) ? CmdEnWr : CmdEnRd;
         end
         default: begin
         end
      endcase
   end

   assign cbus_cmd_array_o = w_cmd;
   assign busy_o           = (r_state != StIdle);
   assign broad_fifo_rd_o  = (r_state == StDone);
   assign cbus_addr_o      = busy_o ? r_addr : '0;
   assign active_id_o      = busy_o ? r_id : '0;
   assign done_cnt_o       = r_done_cnt;

endmodule

// File: tb/tb_mesi_isc_broad_sched.sv
// Randomized bench for mesi_isc_broad_sched: a queue-backed FIFO feeds the DUT and a
// transaction-level model predicts every output each cycle.
module tb_mesi_isc_broad_sched;

   localparam int AW = 32;
   localparam int IW = 7;

   logic           clk = 1'b0;
   logic           rst;
   logic           empty;
   logic [AW-1:0]  addr;
   logic [1:0]     btype;
   logic [1:0]     cpu;
   logic [IW-1:0]  id;
   logic [3:0]     ack;
   logic           rd;
   logic [11:0]    cmd;
   logic [AW-1:0]  caddr;
   logic [IW-1:0]  aid;
   logic           busy;
   logic [15:0]    cnt;

   always #5 clk = ~clk;

   mesi_isc_broad_sched dut (
      .clk                       (clk),
      .rst                       (rst),
      .broad_fifo_status_empty_i (empty),
      .broad_addr_i              (addr),
      .broad_type_i              (btype),
      .broad_cpu_id_i            (cpu),
      .broad_id_i                (id),
      .cbus_ack_array_i          (ack),
      .broad_fifo_rd_o           (rd),
      .cbus_cmd_array_o          (cmd),
      .cbus_addr_o               (caddr),
      .active_id_o               (aid),
      .busy_o                    (busy),
      .done_cnt_o                (cnt)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [1:0]    t;
      logic [1:0]    cpu;
      logic [IW-1:0] id;
   } entry_t;

   entry_t fifo[$];
   int     checks = 0;
   int     errors = 0;

   // Model: an entry in flight, the lanes that still owe a snoop ack, and whether the
   // entry is in its pop cycle.
   bit          m_busy;
   bit          m_popping;
   logic [3:0]  m_snoop_left;
   entry_t      m_cur;
   logic [15:0] m_cnt;

   bit          ack_all;
   bit          rst_req;
   bit          rd_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] exp_cmd();
      logic [11:0] v;
      v = '0;
      if (m_busy && !m_popping) begin
         if (m_snoop_left != 4'h0) begin
            for (int l = 0; l < 4; l++) begin
               if (m_snoop_left[l]) v[l*3 +: 3] = (m_cur.t == 2'd1) ? 3'd1 : 3'd2;
            end
         end else begin
            v[m_cur.cpu*3 +: 3] = (m_cur.t == 2'd1) ? 3'd3 : 3'd4;
         end
      end
      return v;
   endfunction

   task automatic model_reset();
      m_busy       = 1'b0;
      m_popping    = 1'b0;
      m_snoop_left = '0;
      m_cur        = '0;
      m_cnt        = '0;
   endtask

   task automatic compare_all();
      check("busy", 32'(busy), 32'(m_busy));
      check("pop", 32'(rd), 32'(m_busy && m_popping));
      check("addr", caddr, m_busy ? m_cur.addr : 32'h0);
      check("active_id", 32'(aid), m_busy ? 32'(m_cur.id) : 32'h0);
      check("cmd", 32'(cmd), 32'(exp_cmd()));
      check("done_cnt", 32'(cnt), 32'(m_cnt));
   endtask

   task automatic model_edge();
      if (!m_busy) begin
         if (!empty) begin
            m_cur.addr = addr;
            m_cur.t    = btype;
            m_cur.cpu  = cpu;
            m_cur.id   = id;
            m_busy     = 1'b1;
            if (btype == 2'd1 || btype == 2'd2) begin
               m_snoop_left = 4'hF & ~(4'b0001 << cpu);
               m_popping    = 1'b0;
            end else begin
               m_snoop_left = '0;
               m_popping    = 1'b1;
            end
         end
      end else if (m_popping) begin
         m_busy    = 1'b0;
         m_popping = 1'b0;
      end else if (m_snoop_left != 4'h0) begin
         m_snoop_left = m_snoop_left & ~ack;
      end else if (ack[m_cur.cpu]) begin
         m_popping = 1'b1;
         m_cnt     = m_cnt + 16'd1;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      compare_all();
      rd_seen = rd;
      empty = (fifo.size() == 0);
      if (fifo.size() != 0) begin
         {addr, btype, cpu, id} = fifo[0];
      end else begin
         addr  = $urandom;
         btype = 2'($urandom);
         cpu   = 2'($urandom);
         id    = 7'($urandom);
      end
      ack = ack_all ? 4'hF : 4'($urandom & $urandom);
      @(posedge clk);
      model_edge();
      if (rd_seen && fifo.size() != 0) void'(fifo.pop_front());
   endtask

   task automatic mid_reset();
      #2 rst = 1'b1;
      model_reset();
      #1;
      compare_all();
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      while ((fifo.size() != 0 || m_busy) && n < max_cycles) begin
         if (rst_req && m_busy && !m_popping && m_snoop_left != 4'h0) begin
            rst_req = 1'b0;
            mid_reset();
         end
         cycle();
         n++;
      end
      check("drain_bound", 32'(n < max_cycles), 32'd1);
   endtask

   task automatic push(input logic [AW-1:0] a, input logic [1:0] t, input logic [1:0] c,
                       input logic [IW-1:0] i);
      entry_t e;
      e.addr = a;
      e.t    = t;
      e.cpu  = c;
      e.id   = i;
      fifo.push_back(e);
   endtask

   initial begin
      rst     = 1'b1;
      empty   = 1'b1;
      addr    = '0;
      btype   = '0;
      cpu     = '0;
      id      = '0;
      ack     = '0;
      ack_all = 1'b1;
      rst_req = 1'b0;
      rd_seen = 1'b0;
      model_reset();
      #3;
      compare_all();
      @(posedge clk);
      #2 rst = 1'b0;

      // Single WR broadcast from CPU2 with zero-wait acks.
      push(32'h1000, 2'd1, 2'd2, 7'd5);
      drain(20);
      for (int k = 0; k < 2; k++) cycle();
      check("cnt_after_wr", 32'(cnt), 32'd1);

      // Dropped entry (type 0) then two back-to-back valid entries.
      push(32'hDEAD_0000, 2'd0, 2'd1, 7'd9);
      push(32'h2000, 2'd2, 2'd0, 7'd3);
      push(32'h3000, 2'd1, 2'd3, 7'd4);
      drain(40);
      check("cnt_after_b2b", 32'(cnt), 32'd3);

      // Random traffic with random ack timing and one mid-snoop reset.
      ack_all = 1'b0;
      rst_req = 1'b1;
      for (int k = 0; k < 60; k++) begin
         push($urandom, 2'($urandom_range(0, 3)), 2'($urandom), 7'($urandom));
      end
      drain(4000);
      check("reset_taken", 32'(rst_req), 32'd0);
      for (int k = 0; k < 3; k++) cycle();

      // Counter wrap: preload to all-ones, then one completion.
      ack_all = 1'b1;
      force dut.r_done_cnt = 16'hFFFF;
      #1 release dut.r_done_cnt;
      m_cnt = 16'hFFFF;
      push(32'h4000, 2'd2, 2'd1, 7'd7);
      drain(20);
      for (int k = 0; k < 2; k++) cycle();
      check("cnt_wrap", 32'(cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
